// File: rtl/spi_mem_pkg.sv
// Shared types and constants for the SPI memory read engine.
// Optional build macro: SPI_MEM_FAST_READ_EN selects the FAST READ (0x0B) command with
// eight dummy clocks after the address; otherwise the plain READ (0x03) command is used.
package spi_mem_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StCsSetup,
    StHdr,
    StData,
    StStall,
    StCsHold,
    StFinish
  } spi_state_t;

  localparam logic [7:0]  CMD_READ      = 8'h03;
  localparam logic [7:0]  CMD_FAST_READ = 8'h0B;
  localparam int unsigned ADDR_W        = 24;

`ifdef SPI_MEM_FAST_READ_EN
  // Command, address, then one byte of dummy clocks with MOSI low.
  localparam int unsigned HDR_BITS = 40;
`else
  localparam int unsigned HDR_BITS = 32;
`endif

  // Serial header shifted out MSB first ahead of the data phase.
  function automatic logic [HDR_BITS-1:0] hdr_build(input logic [ADDR_W-1:0] addr);
`ifdef SPI_MEM_FAST_READ_EN
    return {CMD_FAST_READ, addr, 8'h00};
`else
    return {CMD_READ, addr};
`endif
  endfunction

endpackage

// File: rtl/spi_mem_reader_if.sv
// Request, byte-stream and SPI pin bundle of the SPI memory read engine.
// slave: the read engine itself; master: the control/downstream/pin side facing it.
interface spi_mem_reader_if
  import spi_mem_pkg::*;
#(
  parameter int unsigned LEN_W = 16
) ();

  logic              start;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              busy;
  logic              done;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              rd_ready;
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_miso;
  logic              spi_cs_n;

  modport slave (
    input  start, addr, len, rd_ready, spi_miso,
    output busy, done, rd_data, rd_valid, spi_clk, spi_mosi, spi_cs_n
  );

  modport master (
    output start, addr, len, rd_ready, spi_miso,
    input  busy, done, rd_data, rd_valid, spi_clk, spi_mosi, spi_cs_n
  );

endinterface

// File: rtl/spi_clk_gen.sv
// SPI clock divider: each half-period lasts CLK_DIV cycles. rise_o/fall_o flag the cycle whose
// closing edge drives sclk_o 0->1 / 1->0. hold_i parks the clock low and restarts the low phase,
// so the owner must only raise it while the clock is already low.
module spi_clk_gen #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic hold_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int unsigned CntW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            sclk_q, sclk_d;
  logic            run, tick;

  // Half-period counter and toggle decision.
  always_comb begin
    run    = en_i && !hold_i;
    tick   = (cnt_q == CntW'(CLK_DIV - 1));
    cnt_d  = cnt_q;
    sclk_d = sclk_q;
    rise_o = run && tick && !sclk_q;
    fall_o = run && tick && sclk_q;
    if (!run) begin
      cnt_d  = '0;
      sclk_d = 1'b0;
    end else if (tick) begin
      cnt_d  = '0;
      sclk_d = !sclk_q;
    end else begin
      cnt_d  = cnt_q + 1'b1;
    end
  end

  // Divider state, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      sclk_q <= sclk_d;
    end
  end

  assign sclk_o = sclk_q;

endmodule

// File: rtl/spi_mem_reader.sv
// SPI mode-0 master read engine: issues READ + 24-bit address, shifts in len bytes and hands
// each one downstream over rd_valid/rd_ready, parking SPI_CLK low while a byte is pending.
// Optional build macro: SPI_MEM_FAST_READ_EN (FAST READ command plus eight dummy clocks).
module spi_mem_reader
  import spi_mem_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned CS_GAP  = 4
) (
  input logic              CLKA,
  input logic              rst_n,
  spi_mem_reader_if.slave  bus
);

  localparam int unsigned WaitW = $clog2(CLK_DIV + CS_GAP + 1);
  localparam int unsigned BitW  = 6;

  spi_state_t          state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [LEN_W-1:0]    rem_q;
  logic [HDR_BITS-1:0] hdr_q;
  logic [BitW-1:0]     bit_q;
  logic [7:0]          shift_q;
  logic [WaitW-1:0]    wait_q;
  logic                cs_n_q, busy_q, done_q, valid_q;
  logic [7:0]          data_q;

  logic sclk, rise, fall;
  logic clk_en, clk_hold;
  logic accept, take, byte_end, load, last, hdr_start, hold_enter;

  spi_clk_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_gen (
    .clk_i  (CLKA),
    .rst_ni (rst_n),
    .en_i   (clk_en),
    .hold_i (clk_hold),
    .sclk_o (sclk),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Next-state and per-cycle strobes.
  always_comb begin
    state_d    = state_q;
    accept     = (state_q == StIdle) && bus.start;
    take       = valid_q && bus.rd_ready;
    byte_end   = (state_q == StData) && fall && (bit_q == '0);
    last       = (rem_q == LEN_W'(1));
    // A finished byte may load when the holding slot is empty or being emptied this cycle.
    load       = (byte_end && (!valid_q || bus.rd_ready)) || ((state_q == StStall) && take);
    hdr_start  = (state_q == StCsSetup) && (wait_q == '0);
    clk_en     = (state_q == StHdr) || (state_q == StData) || (state_q == StStall);
    clk_hold   = (state_q == StStall);
    case (state_q)
      StIdle:    if (bus.start) state_d = (bus.len == '0) ? StFinish : StCsSetup;
      StCsSetup: if (wait_q == '0) state_d = StHdr;
      StHdr:     if (fall && (bit_q == '0)) state_d = StData;
      StData:    if (byte_end) state_d = load ? (last ? StCsHold : StData) : StStall;
      StStall:   if (load) state_d = last ? StCsHold : StData;
      StCsHold:  if (wait_q == '0) state_d = StFinish;
      StFinish:  state_d = StIdle;
      default:   state_d = StIdle;
    endcase
    hold_enter = (state_d == StCsHold) && (state_q != StCsHold);
  end

  // FSM state register.
  always_ff @(posedge CLKA) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // Request latches, timers, serial shifters and the one-byte output slot.
  always_ff @(posedge CLKA) begin
    if (!rst_n) begin
      addr_q  <= '0;
      rem_q   <= '0;
      hdr_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      wait_q  <= '0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      done_q <= (state_q == StFinish);

      if (accept) begin
        addr_q <= bus.addr;
        busy_q <= 1'b1;
        if (bus.len != '0) cs_n_q <= 1'b0;
      end else if (state_q == StFinish) begin
        busy_q <= 1'b0;
      end

      // One down-counter serves both the CS setup delay and the trailing low phase + CS gap.
      if (accept) begin
        wait_q <= WaitW'(CLK_DIV - 1);
      end else if (hold_enter) begin
        wait_q <= WaitW'(CLK_DIV + CS_GAP - 1);
      end else if (wait_q != '0) begin
        wait_q <= wait_q - 1'b1;
      end

      if ((state_q == StCsHold) && (wait_q == WaitW'(CS_GAP))) cs_n_q <= 1'b1;

      // MOSI is the header MSB; zeros shift in behind it, so the data phase drives 0.
      if (hdr_start) begin
        hdr_q <= hdr_build(addr_q);
      end else if ((state_q == StHdr) && fall) begin
        hdr_q <= hdr_q << 1;
      end

      if (hdr_start) begin
        bit_q <= BitW'(HDR_BITS - 1);
      end else if (fall && ((state_q == StHdr) || (state_q == StData))) begin
        bit_q <= (bit_q == '0) ? BitW'(7) : bit_q - 1'b1;
      end

      if (rise) shift_q <= {shift_q[6:0], bus.spi_miso};

      if (accept) begin
        rem_q <= bus.len;
      end else if (load) begin
        rem_q <= rem_q - LEN_W'(1);
      end

      if (load) begin
        data_q  <= shift_q;
        valid_q <= 1'b1;
      end else if (take) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.rd_data  = data_q;
  assign bus.rd_valid = valid_q;
  assign bus.spi_clk  = sclk;
  assign bus.spi_mosi = hdr_q[HDR_BITS-1];
  assign bus.spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_mem_reader.sv
// Directed bench for spi_mem_reader with a toggling MISO model and pin/stream monitors.
module tb_spi_mem_reader;
  import spi_mem_pkg::*;

  localparam int unsigned CLK_DIV = 4;
  localparam int unsigned LEN_W   = 16;
  localparam int unsigned CS_GAP  = 4;

`ifdef SPI_MEM_FAST_READ_EN
  localparam int         HB      = 40;
  localparam int         DUMMY   = 8;
  localparam logic [7:0] EXP_CMD = 8'h0B;
  localparam int         EXP_CS  = 584;
`else
  localparam int         HB      = 32;
  localparam int         DUMMY   = 0;
  localparam logic [7:0] EXP_CMD = 8'h03;
  localparam int         EXP_CS  = 520;
`endif

  logic CLKA = 1'b0;
  logic rst_n;

  spi_mem_reader_if #(.LEN_W(LEN_W)) bus ();

  spi_mem_reader #(
    .CLK_DIV (CLK_DIV),
    .LEN_W   (LEN_W),
    .CS_GAP  (CS_GAP)
  ) dut (
    .CLKA  (CLKA),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 CLKA = ~CLKA;

  int vectors = 0;
  int miscompares = 0;

  // Monitor state
  logic        clr = 1'b0;
  int          cyc = 0;
  logic        prev_sclk = 1'b0;
  logic        prev_cs_n = 1'b1;
  int          rises = 0;
  logic [95:0] mosi_sr = '0;
  int          cs_low = 0;
  int          done_cnt = 0;
  int          nbytes = 0;
  int          bytes_at_done = 0;
  int          cs_rise_cyc = 0;
  int          done_cyc = 0;
  logic [7:0]  bytes [8];
  logic        pend = 1'b0;
  logic [7:0]  held = '0;
  logic        ow_err = 1'b0;

  initial bus.spi_miso = 1'b0;

  // MISO toggles after every SPI_CLK fall while selected; pins and byte stream are recorded.
  always @(posedge CLKA) begin
    cyc       <= cyc + 1;
    prev_sclk <= bus.spi_clk;
    prev_cs_n <= bus.spi_cs_n;
    if (bus.spi_cs_n) bus.spi_miso <= 1'b0;
    else if (prev_sclk && !bus.spi_clk) bus.spi_miso <= ~bus.spi_miso;
    if (clr) begin
      rises    <= 0;
      mosi_sr  <= '0;
      cs_low   <= 0;
      done_cnt <= 0;
      nbytes   <= 0;
      ow_err   <= 1'b0;
    end else begin
      if (!prev_sclk && bus.spi_clk) begin
        rises   <= rises + 1;
        mosi_sr <= {mosi_sr[94:0], bus.spi_mosi};
      end
      if (!bus.spi_cs_n) cs_low <= cs_low + 1;
      if (!prev_cs_n && bus.spi_cs_n) cs_rise_cyc <= cyc;
      if (bus.done) begin
        done_cnt      <= done_cnt + 1;
        done_cyc      <= cyc;
        bytes_at_done <= nbytes;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        if (nbytes < 8) bytes[nbytes] <= bus.rd_data;
        nbytes <= nbytes + 1;
      end
      if (pend && (!bus.rd_valid || bus.rd_data != held)) ow_err <= 1'b1;
    end
    pend <= bus.rd_valid && !bus.rd_ready && rst_n;
    held <= bus.rd_data;
  end

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLKA);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge CLKA);
    clr = 1'b0;
  endtask

  task automatic pulse_start(input logic [23:0] a, input logic [LEN_W-1:0] l);
    bus.addr  = a;
    bus.len   = l;
    bus.start = 1'b1;
    @(negedge CLKA);
    bus.start = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (bus.done !== 1'b1 && n < 3000) begin
      @(negedge CLKA);
      n++;
    end
    chk(tag, 96'(bus.done), 96'(1));
  endtask

  task automatic wait_valid(input string tag);
    int n = 0;
    while (bus.rd_valid !== 1'b1 && n < 3000) begin
      @(negedge CLKA);
      n++;
    end
    chk(tag, 96'(bus.rd_valid), 96'(1));
  endtask

  // Header bits followed by data_bits zero MOSI bits, as seen on SPI_CLK rises.
  function automatic logic [95:0] exp_mosi(input logic [23:0] a, input int data_bits);
    logic [95:0] v;
    v = 96'({EXP_CMD, a});
    v = v << DUMMY;
    v = v << data_bits;
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.addr     = '0;
    bus.len      = '0;
    bus.rd_ready = 1'b1;
    tick(3);
    chk("rst_cs_n", 96'(bus.spi_cs_n), 96'(1));
    chk("rst_sclk", 96'(bus.spi_clk), 96'(0));
    chk("rst_mosi", 96'(bus.spi_mosi), 96'(0));
    chk("rst_busy", 96'(bus.busy), 96'(0));
    chk("rst_done", 96'(bus.done), 96'(0));
    chk("rst_valid", 96'(bus.rd_valid), 96'(0));
    chk("rst_data", 96'(bus.rd_data), 96'(0));
    rst_n = 1'b1;
    tick(2);

    // Basic read
    do_clr();
    pulse_start(24'h123456, 4);
    chk("basic_busy", 96'(bus.busy), 96'(1));
    chk("basic_cs_low", 96'(bus.spi_cs_n), 96'(0));
    wait_done("basic_done");
    tick(20);
    chk("basic_rises", 96'(rises), 96'(HB + 32));
    chk("basic_mosi", mosi_sr, exp_mosi(24'h123456, 32));
    chk("basic_nbytes", 96'(nbytes), 96'(4));
    chk("basic_bytes", 96'({bytes[0], bytes[1], bytes[2], bytes[3]}), 96'(32'h55555555));
    chk("basic_cs_cycles", 96'(cs_low), 96'(EXP_CS));
    // CS_GAP high cycles in CS_HOLD, one FINISH cycle, then done
    chk("basic_cs_to_done", 96'(done_cyc - cs_rise_cyc), 96'(CS_GAP + 1));
    chk("basic_done_cnt", 96'(done_cnt), 96'(1));
    chk("basic_busy_end", 96'(bus.busy), 96'(0));

    // Backpressure: first byte left pending, byte 2 must park the clock
    do_clr();
    bus.rd_ready = 1'b0;
    pulse_start(24'h123456, 4);
    wait_valid("bp_first_byte");
    tick(90);
    chk("bp_stall_rises", 96'(rises), 96'(HB + 16));
    chk("bp_stall_sclk", 96'(bus.spi_clk), 96'(0));
    chk("bp_stall_data", 96'(bus.rd_data), 96'(8'h55));
    chk("bp_stall_valid", 96'(bus.rd_valid), 96'(1));
    tick(9);
    chk("bp_stall_hold", 96'(rises), 96'(HB + 16));
    bus.rd_ready = 1'b1;
    wait_done("bp_done");
    tick(20);
    chk("bp_nbytes", 96'(nbytes), 96'(4));
    chk("bp_bytes", 96'({bytes[0], bytes[1], bytes[2], bytes[3]}), 96'(32'h55555555));
    chk("bp_no_overwrite", 96'(ow_err), 96'(0));
    chk("bp_bytes_at_done", 96'(bytes_at_done), 96'(4));
    chk("bp_rises", 96'(rises), 96'(HB + 32));
    chk("bp_done_cnt", 96'(done_cnt), 96'(1));

    // len = 0: no chip select, done two cycles after start
    do_clr();
    pulse_start(24'hABCDEF, 0);
    chk("len0_busy", 96'(bus.busy), 96'(1));
    chk("len0_done_early", 96'(bus.done), 96'(0));
    chk("len0_cs", 96'(bus.spi_cs_n), 96'(1));
    tick(1);
    chk("len0_done", 96'(bus.done), 96'(1));
    chk("len0_busy_drop", 96'(bus.busy), 96'(0));
    chk("len0_sclk", 96'(bus.spi_clk), 96'(0));
    tick(1);
    chk("len0_done_pulse", 96'(bus.done), 96'(0));
    chk("len0_cs_cycles", 96'(cs_low), 96'(0));
    chk("len0_rises", 96'(rises), 96'(0));

    // Start while busy is ignored
    do_clr();
    pulse_start(24'hA5C3E1, 1);
    tick(60);
    pulse_start(24'hFFFFFF, 3);
    wait_done("busy_done");
    tick(50);
    chk("busy_mosi", mosi_sr, exp_mosi(24'hA5C3E1, 8));
    chk("busy_done_cnt", 96'(done_cnt), 96'(1));
    chk("busy_nbytes", 96'(nbytes), 96'(1));
    chk("busy_byte", 96'(bytes[0]), 96'(8'h55));
    chk("busy_idle", 96'(bus.busy), 96'(0));

    // Reset in the middle of byte 2, then a normal transfer
    do_clr();
    bus.rd_ready = 1'b0;
    pulse_start(24'h000100, 4);
    wait_valid("rst_first_byte");
    tick(30);
    chk("rstm_busy_pre", 96'(bus.busy), 96'(1));
    chk("rstm_valid_pre", 96'(bus.rd_valid), 96'(1));
    rst_n = 1'b0;
    tick(1);
    chk("rstm_cs_n", 96'(bus.spi_cs_n), 96'(1));
    chk("rstm_valid", 96'(bus.rd_valid), 96'(0));
    chk("rstm_busy", 96'(bus.busy), 96'(0));
    chk("rstm_sclk", 96'(bus.spi_clk), 96'(0));
    rst_n = 1'b1;
    bus.rd_ready = 1'b1;
    tick(100);
    chk("rstm_no_done", 96'(done_cnt), 96'(0));
    do_clr();
    pulse_start(24'h000100, 2);
    wait_done("rstm_restart_done");
    tick(20);
    chk("rstm_nbytes", 96'(nbytes), 96'(2));
    chk("rstm_bytes", 96'({bytes[0], bytes[1]}), 96'(16'h5555));
    chk("rstm_rises", 96'(rises), 96'(HB + 16));
    chk("rstm_mosi", mosi_sr, exp_mosi(24'h000100, 16));
    chk("rstm_done_cnt", 96'(done_cnt), 96'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/spi_mem_reader.md
Name: spi_mem_reader

Overview:
- SPI master read engine driving the external serial memory pins (SPI_CLK, SPI_MOSI, SPI_CS_n, SPI_MISO) inside top.
- Takes a start/address/length request from the control logic and issues a READ (0x03) command with a 24-bit address.
- Shifts in the requested number of bytes and hands each byte downstream (e.g. to the UART transmit path) over a valid/ready interface.
- Stalls the SPI clock at byte boundaries when the downstream side applies backpressure.

Parameters:
- CLK_DIV, 4: CLKA cycles per SPI_CLK half-period; legal range ≥2.
- LEN_W, 16: width of the byte-count request.
- CS_GAP, 4: CLKA cycles CS_n is held high after a transfer before the block returns to idle.

Ports:
- CLKA  in  1  system clock; sole clock domain.
- rst_n  in  1  synchronous active-low reset.
- start  in  1  one-cycle request strobe; sampled only in IDLE.
- addr  in  24  start byte address; latched on an accepted start.
- len  in  LEN_W  byte count; latched on an accepted start.
- busy  out  1  high from an accepted start until done.
- done  out  1  one-cycle pulse when the transfer completes.
- rd_data  out  8  received byte.
- rd_valid  out  1  rd_data holds an unconsumed byte.
- rd_ready  in  1  downstream accepts a byte when rd_valid && rd_ready.
- spi_clk  out  1  SPI clock, mode 0, idles low.
- spi_mosi  out  1  serial command/address, MSB first.
- spi_miso  in  1  serial read data, MSB first.
- spi_cs_n  out  1  chip select, active low.

Behaviour:
- Reset (rst_n low at a CLKA edge) values: spi_cs_n=1, spi_clk=0, spi_mosi=0, busy=0, done=0, rd_valid=0, rd_data=0, state=IDLE.
- Reset mid-transfer aborts at once: CS_n rises on that same edge and no done pulse is produced.
- FSM states: IDLE, CS_SETUP, HDR, DATA, STALL, CS_HOLD, FINISH.
- IDLE, start=1 and len≠0:
  - latch addr/len, load the 32-bit header {cmd, addr};
  - busy=1, spi_cs_n=0 on the next edge;
  - go to CS_SETUP.
- IDLE, start=1 and len=0: go to FINISH directly; CS is never asserted.
- IDLE, start=0: stay in IDLE.
- start while busy: ignored, with no effect on the transfer in progress.
- CS_SETUP: holds CS low and clock low for CLK_DIV cycles, then goes to HDR.
- Bit timing, for each bit:
  - spi_clk low for CLK_DIV cycles, then high for CLK_DIV cycles;
  - spi_mosi changes only on the edge where spi_clk goes 1→0, or at HDR entry for bit 31;
  - spi_miso is sampled into the shift register on the CLKA edge that drives spi_clk 0→1.
- HDR: 32 bits; MOSI carries the header MSB first. After bit 0, go to DATA. MISO samples taken during HDR are discarded.
- DATA: 8 bits per byte; MOSI=0. At the end of each byte's high phase:
  - If rd_valid=0, or rd_ready=1 this cycle: load rd_data with the shifted byte, set rd_valid=1, decrement the remaining count.
  - Otherwise go to STALL.
- STALL: spi_clk held low. Leave STALL on the edge the pending byte is accepted; the new byte is loaded that same edge.
- After the last byte is loaded, go to CS_HOLD: clock low, then CS_n=1 for CS_GAP cycles, then FINISH.
- FINISH: done=1 for one cycle, busy=0, return to IDLE.
- rd_valid stays high until accepted and is independent of the FSM state. It may remain high after done; the final byte is still delivered.
- Downstream side holds at most one byte. No byte is ever dropped or overwritten.
- Remaining-byte counter is LEN_W bits, decremented once per loaded byte, and does not wrap.
- Byte-boundary stalls lengthen the SPI_CLK low phase only; the high phase is never truncated.

Optional Feature:
- Macro SPI_MEM_FAST_READ_EN.
- Defined: command is 0x0B, followed by 8 dummy clocks (MOSI=0, MISO discarded) after the address; the header phase becomes 40 bits.
- Undefined: command is 0x03 and the header is 32 bits.
- All other timing is identical in both builds.

Decomposition:
- Package spi_mem_pkg holds:
  - state enum spi_state_t;
  - constants CMD_READ=8'h03, CMD_FAST_READ=8'h0B, ADDR_W=24, HDR_BITS.
- One sub-module, spi_clk_gen: divider producing the rise/fall strobes with a hold input that stalls the clock low. The FSM and shift logic stay in spi_mem_reader.

Test Plan:
- Basic read. Setup: CLK_DIV=4, addr=0x123456, len=4, rd_ready=1, MISO modelled to toggle on each SPI_CLK falling edge, starting at 0 when CS falls. Required response:
  - MOSI carries 0x03,0x12,0x34,0x56;
  - four bytes of 0x55 are delivered;
  - exactly 64 SPI_CLK rising edges occur;
  - CS low for 4+512+4 CLKA cycles, then done one cycle later.
- Backpressure: same as basic read, but rd_ready=0 for 100 cycles after the first byte. Required response:
  - spi_clk stays low after byte 2 completes;
  - no overwrite; bytes delivered are 0x55 ×4;
  - done is asserted after the last byte is accepted.
- len=0: start with len=0 → CS_n stays 1, spi_clk stays 0, done pulses two cycles after start, busy drops with it.
- Start while busy: start pulsed mid-HDR with addr=0xFFFFFF → MOSI still carries the original address and only one done pulse occurs.
- Reset mid-DATA: rst_n low for one cycle during byte 2 → on that edge CS_n=1, rd_valid=0, busy=0; no done pulse; a new start then works normally.
- Fast-read build: with SPI_MEM_FAST_READ_EN defined and the basic-read stimulus → MOSI is 0x0B, address, 0x00; 72 rising edges occur; data is 0x55 ×4.
